sha256_msg_loader: RTL and testbench
====================================

Name: sha256_msg_loader

Overview:
Source-side feeder for the SHA-256 core. Accepts a raw message as a byte stream and applies standard SHA-256 padding: a 0x80 byte, zero fill, then the 64-bit big-endian bit length. It delivers each 512-bit block to the core as 16 consecutive 32-bit words on data_prepro/data_load, gated by the core's input_ready. It replaces the software-side CPU feeder in the integrated design.

Parameters:
LEN_W, 32, width of the internal message byte counter; the bit length field is {zeros, byte_cnt, 3'b000} zero-extended to 64 bits.

Ports:
clk  input  1  system clock; single clock domain.
rst_n  input  1  asynchronous, active-low reset.
in_data  input  8  message byte.
in_valid  input  1  in_data valid.
in_last  input  1  marks the final byte of the message; qualified by in_valid.
in_ready  output  1  loader accepts a byte this cycle.
input_ready  input  1  core can accept a new 16-word block.
data_prepro  output  32  block word to the core, big-endian; first byte goes in [31:24].
data_load  output  1  data_prepro valid; high for exactly 16 consecutive cycles per block.
data_first  output  1  high with word 0 of the first block of each message.
msg_done  output  1  one-cycle pulse the cycle after word 15 of the final block.

Behaviour:
- Reset values: in_ready=0, data_load=0, data_first=0, msg_done=0, data_prepro=0. Internal state: byte_idx=0, byte_cnt=0, FSM=FILL, first flag=1.
- Internal storage: 64-byte block buffer (16x32). byte_idx (6 bits) is the write position.
- FSM states: FILL, PAD, LEN, SEND, DONE.
- FILL:
  - in_ready=1.
  - A byte is accepted on in_valid&&in_ready. It is written at byte_idx; byte_idx increments and byte_cnt increments.
  - Accepted byte with in_last=1: go to PAD. If byte_idx wraps to 0 on that byte, go to SEND first with pad_pending set.
  - Otherwise, if byte_idx wraps to 0: go to SEND.
- PAD:
  - in_ready=0. Writes one byte per cycle.
  - First cycle writes 0x80, then writes 0x00 until byte_idx==56, then goes to LEN.
  - If byte_idx wraps to 0 before reaching 56: go to SEND, then return to PAD (zeros only) for the next block.
- LEN: writes the 8 length bytes MSB first, one per cycle (byte_idx 56..63), then goes to SEND with final flag set.
- SEND:
  - in_ready=0. The loader waits for input_ready=1.
  - The cycle after input_ready is sampled high, data_load=1 for 16 cycles with words 0..15 in order.
  - input_ready is ignored once streaming starts.
  - data_first=1 on word 0 if the first flag is set; the first flag is then cleared.
  - After word 15: if final, go to DONE. Else if pad_pending, go to PAD. Else if in LEN/PAD continuation, return there. Otherwise go to FILL.
- DONE: msg_done=1 for one cycle. byte_cnt=0, first flag=1, byte_idx=0, then go to FILL.
- Minimum message length is 1 byte; empty messages are unsupported.
- Latency for a 1-byte message: the 1-byte accept, 55 PAD cycles, 8 LEN cycles, then SEND.
- in_valid while in_ready=0 is held by the source and is not dropped.
- byte_cnt saturation is undefined unless LOADER_ERR_EN is defined.
- rst_n assertion at any time, including mid-SEND, returns everything to reset values immediately. A partially streamed block is abandoned.

Optional Feature:
LOADER_ERR_EN
- Defined:
  - Adds output len_err (1 bit, reset 0). It sets when a byte is accepted with byte_cnt all-ones.
  - While len_err=1, further bytes are accepted and discarded.
  - It clears in DONE.
- Undefined: no len_err port, and byte_cnt wraps silently.

Test Plan:
- "abc" (0x61,0x62,0x63, last on 0x63), input_ready=1 -> one block: W0=0x61626380, W1..W14=0, W15=0x00000018; data_first on W0; msg_done one cycle after W15.
- 55-byte message of 0x41 -> single block: W13=0x41414180, W14=0, W15=0x000001B8.
- 56-byte message -> two blocks: block1 W14=0x80000000, W15=0; block2 W0..W14=0, W15=0x000001C0; data_first only on block1 W0.
- 64-byte message -> two blocks: block2 W0=0x80000000, W15=0x00000200; in_ready=0 throughout both SENDs.
- input_ready held low for 20 cycles while in SEND -> data_load stays 0. Raising input_ready gives exactly 16 load cycles starting the next cycle. Dropping input_ready mid-stream does not pause the stream.
- rst_n pulsed low at word 7 of a SEND -> data_load=0 immediately. A subsequent "abc" produces the exact vector from the first test with data_first=1.

Source files
------------

// File: rtl/sha256_msg_loader.sv
// SHA-256 message loader: byte stream in, padded 16-word blocks out.
// Optional LOADER_ERR_EN adds a sticky len_err output on counter overflow.
module sha256_msg_loader #(
  parameter int LEN_W = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  input  logic        input_ready,
  output logic [31:0] data_prepro,
  output logic        data_load,
  output logic        data_first,
`ifdef LOADER_ERR_EN
  output logic        msg_done,
  output logic        len_err
`else
  output logic        msg_done
`endif
);

  typedef enum logic [2:0] {
    FILL,
    PAD,
    LEN,
    SEND,
    DONE
  } state_t;

  state_t           state_q;
  logic [5:0]       byte_idx;
  logic [LEN_W-1:0] byte_cnt;
  logic             first_q;
  logic             final_q;
  logic             pad_pend_q;
  logic             cont_q;
  logic             pad_zero_q;
  logic [4:0]       w_cnt;

  logic [7:0]       mem [64];

  logic             accept;
  logic             drop;
  logic             wrap;
  logic [5:0]       idx_nxt;
  logic             wr_en;
  logic [7:0]       wr_byte;
  logic [63:0]      len_bits;
  logic [2:0]       lsel;
  logic [31:0]      rd_word;

  assign len_bits = 64'({byte_cnt, 3'b000});
  assign lsel     = 3'd7 - byte_idx[2:0];
  assign idx_nxt  = byte_idx + 6'd1;
  assign wrap     = (byte_idx == 6'd63);
  assign accept   = (state_q == FILL) && in_valid && in_ready;

`ifdef LOADER_ERR_EN
  assign drop = len_err;
`else
  assign drop = 1'b0;
`endif

  // Pick the byte written into the block buffer this cycle.
  always_comb begin
    wr_en   = 1'b0;
    wr_byte = 8'h00;
    unique case (state_q)
      FILL: begin
        wr_en   = accept && !drop;
        wr_byte = in_data;
      end
      PAD: begin
        wr_en   = 1'b1;
        wr_byte = pad_zero_q ? 8'h00 : 8'h80;
      end
      LEN: begin
        wr_en   = 1'b1;
        wr_byte = len_bits[{lsel, 3'b000} +: 8];
      end
      default: begin
        wr_en   = 1'b0;
        wr_byte = 8'h00;
      end
    endcase
  end

  // Big-endian word view of the buffer at the current send index.
  always_comb begin
    rd_word = {mem[{w_cnt[3:0], 2'b00}],
               mem[{w_cnt[3:0], 2'b01}],
               mem[{w_cnt[3:0], 2'b10}],
               mem[{w_cnt[3:0], 2'b11}]};
  end

  // 64-byte block buffer, one byte written per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
    end else if (wr_en) begin
      mem[byte_idx] <= wr_byte;
    end
  end

  // Loader FSM: fill, pad, length, stream block, finish message.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      in_ready    <= 1'b0;
      byte_idx    <= '0;
      byte_cnt    <= '0;
      first_q     <= 1'b1;
      final_q     <= 1'b0;
      pad_pend_q  <= 1'b0;
      cont_q      <= 1'b0;
      pad_zero_q  <= 1'b0;
      w_cnt       <= '0;
      data_prepro <= '0;
      data_load   <= 1'b0;
      data_first  <= 1'b0;
      msg_done    <= 1'b0;
`ifdef LOADER_ERR_EN
      len_err     <= 1'b0;
`endif
    end else begin
      msg_done   <= 1'b0;
      data_first <= 1'b0;
      unique case (state_q)
        FILL: begin
          in_ready <= 1'b1;
          if (accept) begin
            if (!drop) begin
              byte_idx <= idx_nxt;
              byte_cnt <= byte_cnt + LEN_W'(1);
            end
`ifdef LOADER_ERR_EN
            if (&byte_cnt) len_err <= 1'b1;
`endif
            if (in_last) begin
              in_ready   <= 1'b0;
              pad_zero_q <= 1'b0;
              if (!drop && wrap) begin
                state_q    <= SEND;
                pad_pend_q <= 1'b1;
              end else begin
                state_q <= PAD;
              end
            end else if (!drop && wrap) begin
              in_ready <= 1'b0;
              state_q  <= SEND;
            end
          end
        end
        PAD: begin
          byte_idx   <= idx_nxt;
          pad_zero_q <= 1'b1;
          if (idx_nxt == 6'd56) begin
            state_q <= LEN;
          end else if (wrap) begin
            state_q <= SEND;
            cont_q  <= 1'b1;
          end
        end
        LEN: begin
          byte_idx <= idx_nxt;
          if (wrap) begin
            state_q <= SEND;
            final_q <= 1'b1;
          end
        end
        SEND: begin
          if (!data_load) begin
            if (input_ready) begin
              data_load   <= 1'b1;
              data_prepro <= rd_word;
              data_first  <= first_q;
              first_q     <= 1'b0;
              w_cnt       <= 5'd1;
            end
          end else if (w_cnt == 5'd16) begin
            data_load   <= 1'b0;
            data_prepro <= '0;
            w_cnt       <= '0;
            if (final_q) begin
              final_q  <= 1'b0;
              msg_done <= 1'b1;
              state_q  <= DONE;
            end else if (pad_pend_q) begin
              pad_pend_q <= 1'b0;
              state_q    <= PAD;
            end else if (cont_q) begin
              cont_q  <= 1'b0;
              state_q <= PAD;
            end else begin
              in_ready <= 1'b1;
              state_q  <= FILL;
            end
          end else begin
            data_prepro <= rd_word;
            w_cnt       <= w_cnt + 5'd1;
          end
        end
        DONE: begin
          byte_cnt <= '0;
          first_q  <= 1'b1;
          byte_idx <= '0;
          in_ready <= 1'b1;
          state_q  <= FILL;
`ifdef LOADER_ERR_EN
          len_err  <= 1'b0;
`endif
        end
        default: state_q <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_loader.sv
// Scoreboard bench for sha256_msg_loader.
// Random and directed messages against a padding reference model.
module tb_sha256_msg_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic        input_ready;
  logic [31:0] data_prepro;
  logic        data_load;
  logic        data_first;
  logic        msg_done;

  always #5 clk = ~clk;

  sha256_msg_loader #(.LEN_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .input_ready (input_ready),
    .data_prepro (data_prepro),
    .data_load   (data_load),
    .data_first  (data_first),
    .msg_done    (msg_done)
  );

  typedef struct {
    logic [31:0] w;
    bit          first;
    bit          last;
  } exp_t;

  exp_t       sb[$];
  int         tests = 0;
  int         fails = 0;
  bit         rand_ir = 1'b0;
  bit         exp_done = 1'b0;
  int         run = 0;
  logic [7:0] msg[$];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference: bytes, 0x80, zeros to 56 mod 64, 64-bit bit length.
  task automatic push_msg(input logic [7:0] m[$]);
    logic [7:0]  p[$];
    logic [63:0] bits;
    int          nw;
    exp_t        e;
    p = m;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bits = 64'(m.size()) * 64'd8;
    for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
    nw = p.size() / 4;
    for (int k = 0; k < nw; k++) begin
      e.w     = {p[4*k], p[4*k+1], p[4*k+2], p[4*k+3]};
      e.first = (k == 0);
      e.last  = (k == nw - 1);
      sb.push_back(e);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic l);
    int n;
    in_data  = b;
    in_valid = 1'b1;
    in_last  = l;
    n = 0;
    while (!in_ready && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 3000) begin
      tests++;
      fails++;
      $display("FAIL in_ready_timeout: got 0 want 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_msg(input logic [7:0] m[$], input int gap);
    push_msg(m);
    for (int i = 0; i < m.size(); i++) begin
      repeat ($urandom_range(0, gap)) begin
        @(posedge clk); #1;
      end
      send_byte(m[i], i == m.size() - 1);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: pops expected words whenever the loader streams one.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n !== 1'b1) begin
      exp_done = 1'b0;
      run = 0;
    end else begin
      if (exp_done || msg_done) begin
        tests++;
        if (msg_done !== exp_done) begin
          fails++;
          $display("FAIL msg_done: got %b want %b", msg_done, exp_done);
        end
      end
      exp_done = 1'b0;
      if (data_load) begin
        run++;
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL extra_word: got %h want none", data_prepro);
        end else begin
          e = sb.pop_front();
          tests++;
          if (data_prepro !== e.w || data_first !== e.first
              || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL word: got %h f%b r%b want %h f%b r0",
                     data_prepro, data_first, in_ready, e.w, e.first);
          end
          exp_done = e.last;
        end
      end else if (run != 0) begin
        tests++;
        if (run != 16) begin
          fails++;
          $display("FAIL burst_len: got %0d want 16", run);
        end
        run = 0;
      end
    end
  end

  // Random input_ready toggling, including drops mid-stream.
  always begin
    @(posedge clk); #1;
    if (rand_ir) input_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n       = 1'b0;
    in_data     = 8'h00;
    in_valid    = 1'b0;
    in_last     = 1'b0;
    input_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_load", 64'(data_load), 64'd0);
    chk("rst_first", 64'(data_first), 64'd0);
    chk("rst_done", 64'(msg_done), 64'd0);
    chk("rst_data", 64'(data_prepro), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    msg = '{8'h61, 8'h62, 8'h63};
    send_msg(msg, 0);
    drain();

    msg.delete();
    repeat (55) msg.push_back(8'h41);
    send_msg(msg, 0);
    drain();

    msg.delete();
    repeat (56) msg.push_back(8'($urandom_range(0, 255)));
    send_msg(msg, 1);
    drain();

    msg.delete();
    repeat (64) msg.push_back(8'($urandom_range(0, 255)));
    send_msg(msg, 1);
    drain();

    input_ready = 1'b0;
    msg = '{8'h61, 8'h62, 8'h63};
    send_msg(msg, 0);
    repeat (80) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("hold_no_load", 64'(data_load), 64'd0);
    end
    input_ready = 1'b1;
    @(posedge clk); #1;
    chk("load_start", 64'(data_load), 64'd1);
    input_ready = 1'b0;
    n = 1;
    repeat (20) begin
      @(posedge clk); #1;
      if (data_load) n++;
    end
    chk("load_cycles", 64'(n), 64'd16);
    drain();

    input_ready = 1'b1;
    msg = '{8'h61, 8'h62, 8'h63};
    send_msg(msg, 0);
    n = 0;
    for (int i = 0; i < 300 && n < 8; i++) begin
      @(posedge clk); #1;
      if (data_load) n++;
    end
    chk("reach_word7", 64'(n), 64'd8);
    rst_n = 1'b0;
    #1;
    chk("midrst_load", 64'(data_load), 64'd0);
    chk("midrst_data", 64'(data_prepro), 64'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_msg(msg, 0);
    drain();

    rand_ir = 1'b1;
    for (int t = 0; t < 6; t++) begin
      msg.delete();
      n = $urandom_range(1, 140);
      repeat (n) msg.push_back(8'($urandom_range(0, 255)));
      send_msg(msg, 2);
    end
    drain();
    rand_ir = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
